// File: rtl/io_input_conditioner.sv
// Switch synchroniser plus per-button debounce FSM with press/release pulses.
// Optional sticky press flag when BTN_STICKY_EN is defined.
module io_input_conditioner #(
  parameter int SW_WIDTH        = 16,
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic [NUM_BTN-1:0]  btn_raw,
  input  logic [NUM_BTN-1:0]  flag_clr,
  output logic [SW_WIDTH-1:0] sw_out,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  btn_press,
  output logic [NUM_BTN-1:0]  btn_release,
  output logic [NUM_BTN-1:0]  btn_flag
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HI,
    HELD,
    WAIT_LO
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sw_s1_q;
  logic [SW_WIDTH-1:0] sw_s2_q;
  logic [NUM_BTN-1:0]  btn_s1_q;
  logic [NUM_BTN-1:0]  btn_s2_q;

  state_e           state_q [NUM_BTN];
  state_e           state_d [NUM_BTN];
  logic [CNT_W-1:0] cnt_q   [NUM_BTN];
  logic [CNT_W-1:0] cnt_d   [NUM_BTN];

  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] rel_q;
  logic [NUM_BTN-1:0] rel_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
    end
  end

  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (btn_s2_q[i]) begin
            state_d[i] = WAIT_HI;
            cnt_d[i]   = '0;
          end
        end
        WAIT_HI: begin
          if (!btn_s2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_s2_q[i]) begin
            state_d[i] = WAIT_LO;
            cnt_d[i]   = '0;
          end
        end
        WAIT_LO: begin
          if (btn_s2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
            rel_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign sw_out      = sw_s2_q;
  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;

`ifdef BTN_STICKY_EN
  logic [NUM_BTN-1:0] flag_q;
  logic [NUM_BTN-1:0] flag_d;

  // A press landing in the same cycle as a clear must survive.
  always_comb begin
    flag_d = (flag_q & ~flag_clr) | press_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= '0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign btn_flag = flag_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr = ^flag_clr;
  assign btn_flag        = '0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner at DEBOUNCE_CYCLES=4.
// Flag expectations follow BTN_STICKY_EN.
module tb_io_input_conditioner;

  logic        clk;
  logic        reset;
  logic [15:0] sw_raw;
  logic [2:0]  btn_raw;
  logic [2:0]  flag_clr;
  logic [15:0] sw_out;
  logic [2:0]  btn_level;
  logic [2:0]  btn_press;
  logic [2:0]  btn_release;
  logic [2:0]  btn_flag;

  int checks = 0;
  int errors = 0;

`ifdef BTN_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  io_input_conditioner #(
    .SW_WIDTH       (16),
    .NUM_BTN        (3),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (18)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .btn_raw    (btn_raw),
    .flag_clr   (flag_clr),
    .sw_out     (sw_out),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_flag   (btn_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] fexp(input logic [2:0] v);
    return STICKY ? v : 3'b000;
  endfunction

  logic [5:0] bounce;

  initial begin
    reset    = 1'b0;
    sw_raw   = 16'hFFFF;
    btn_raw  = 3'b111;
    flag_clr = 3'b000;

    // 1: reset state, then release with inputs held high
    step(2);
    chk("rst_sw", sw_out, 16'h0);
    chk("rst_lvl", {13'd0, btn_level}, 16'h0);
    chk("rst_prs", {13'd0, btn_press}, 16'h0);
    chk("rst_rel", {13'd0, btn_release}, 16'h0);
    chk("rst_flg", {13'd0, btn_flag}, 16'h0);
    reset = 1'b1;
    step(1);
    chk("sw_e1", sw_out, 16'h0);
    step(1);
    chk("sw_e2", sw_out, 16'hFFFF);
    for (int i = 3; i <= 8; i++) begin
      step(1);
      chk("t1_prs", {13'd0, btn_press},
          (i == 7) ? 16'h7 : 16'h0);
      chk("t1_lvl", {13'd0, btn_level},
          (i >= 7) ? 16'h7 : 16'h0);
    end
    chk("t1_flg", {13'd0, btn_flag}, {13'd0, fexp(3'b111)});

    btn_raw = 3'b000;
    sw_raw  = 16'hA5A5;
    step(1);
    chk("sw_old", sw_out, 16'hFFFF);
    step(1);
    chk("sw_new", sw_out, 16'hA5A5);
    for (int i = 3; i <= 8; i++) begin
      step(1);
      chk("t1_rel", {13'd0, btn_release},
          (i == 7) ? 16'h7 : 16'h0);
      chk("t1_rlv", {13'd0, btn_level},
          (i >= 7) ? 16'h0 : 16'h7);
    end
    flag_clr = 3'b111;
    step(1);
    flag_clr = 3'b000;
    chk("t1_clr", {13'd0, btn_flag}, 16'h0);

    // 2: bounce on button 0
    bounce = 6'b111011;
    for (int i = 0; i < 14; i++) begin
      btn_raw[0] = (i < 6) ? bounce[5-i] : 1'b0;
      step(1);
      chk("t2_prs", {13'd0, btn_press}, 16'h0);
      chk("t2_lvl", {13'd0, btn_level}, 16'h0);
    end

    // 3: clean press on button 1 held for 20 cycles
    btn_raw = 3'b010;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      chk("t3_prs", {13'd0, btn_press},
          (i == 7) ? 16'h2 : 16'h0);
      chk("t3_lvl", {13'd0, btn_level},
          (i >= 7) ? 16'h2 : 16'h0);
    end
    btn_raw = 3'b000;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk("t3_rel", {13'd0, btn_release},
          (i == 7) ? 16'h2 : 16'h0);
      chk("t3_rlv", {13'd0, btn_level},
          (i >= 7) ? 16'h0 : 16'h2);
      chk("t3_np", {13'd0, btn_press}, 16'h0);
    end

    // 4/5: sticky flag on button 2
    btn_raw = 3'b100;
    step(7);
    chk("t4_prs", {13'd0, btn_press}, 16'h4);
    chk("t4_set", {13'd0, btn_flag}, {13'd0, fexp(3'b100)});
    btn_raw = 3'b000;
    step(50);
    chk("t4_hold", {13'd0, btn_flag}, {13'd0, fexp(3'b100)});
    chk("t4_idle", {13'd0, btn_level}, 16'h0);
    flag_clr = 3'b100;
    step(1);
    flag_clr = 3'b000;
    chk("t4_clr", {13'd0, btn_flag}, 16'h0);
    btn_raw = 3'b100;
    step(6);
    chk("t4_pre", {13'd0, btn_press}, 16'h0);
    flag_clr = 3'b100;
    step(1);
    flag_clr = 3'b000;
    chk("t4_prs2", {13'd0, btn_press}, 16'h4);
    chk("t4_win", {13'd0, btn_flag}, {13'd0, fexp(3'b100)});
    step(1);
    chk("t4_keep", {13'd0, btn_flag}, {13'd0, fexp(3'b100)});
    btn_raw = 3'b000;
    step(10);
    chk("t4_off", {13'd0, btn_level}, 16'h0);

    // 6: reset mid-count
    btn_raw = 3'b010;
    step(8);
    chk("t6_lvl", {13'd0, btn_level}, 16'h2);
    btn_raw = 3'b011;
    step(5);
    chk("t6_cnt", {13'd0, btn_press}, 16'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_alvl", {13'd0, btn_level}, 16'h0);
    chk("t6_asw", sw_out, 16'h0);
    chk("t6_aflg", {13'd0, btn_flag}, 16'h0);
    step(1);
    chk("t6_hold", {13'd0, btn_press | btn_level}, 16'h0);
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("t6_prs", {13'd0, btn_press},
          (i == 7) ? 16'h3 : 16'h0);
      chk("t6_rel", {13'd0, btn_release}, 16'h0);
    end
    chk("t6_sw", sw_out, 16'hA5A5);
    chk("t6_flv", {13'd0, btn_level}, 16'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
